dc_token_data_buffer: RTL and testbench

//  Single-clock FIFO storage stage addressed by two one-hot token rings (write, read).

---
 rtl/dc_token_pkg.sv | 22 ++
 rtl/dc_token_data_buffer_if.sv | 29 ++
 rtl/dc_token_ring_sync.sv | 22 ++
 rtl/dc_token_data_buffer.sv | 91 +++++++++
 tb/tb_dc_token_data_buffer.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/dc_token_pkg.sv
// Shared one-hot token helpers for the token-addressed FIFO storage.
// Functions work on a fixed maximum width; callers cast their rings in and out.
package dc_token_pkg;

  localparam int TOK_MAX = 64;
  typedef logic [TOK_MAX-1:0] tok_t;

  localparam tok_t TOK_RST = tok_t'(1);

  // Rotate left by one within the low 'depth' bits; the bit at depth-1 wraps to bit 0.
  function automatic tok_t tok_rotl(tok_t tok, int unsigned depth);
    tok_t m;
    m = {TOK_MAX{1'b1}} >> (TOK_MAX - depth);
    return ((tok << 1) | (tok >> (depth - 1))) & m;
  endfunction

  // One-hot select of a single bit column across all slots.
  function automatic logic tok_mux(tok_t tokens, tok_t slots);
    return |(tokens & slots);
  endfunction

endpackage

// File: rtl/dc_token_data_buffer_if.sv
// Handshake bundle for dc_token_data_buffer; level/almost_full exist only
// when DC_TOKEN_BUF_LEVEL_EN is defined.
interface dc_token_data_buffer_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int BUFFER_DEPTH = 8
);
    logic                  flush;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
`ifdef DC_TOKEN_BUF_LEVEL_EN
    localparam int LW = $clog2(BUFFER_DEPTH + 1);
    logic [LW-1:0]         level;
    logic                  almost_full;

    modport master (output flush, in_data, in_valid, out_ready,
                    input  in_ready, out_data, out_valid, level, almost_full);
    modport slave  (input  flush, in_data, in_valid, out_ready,
                    output in_ready, out_data, out_valid, level, almost_full);
`else
    modport master (output flush, in_data, in_valid, out_ready,
                    input  in_ready, out_data, out_valid);
    modport slave  (input  flush, in_data, in_valid, out_ready,
                    output in_ready, out_data, out_valid);
`endif
endinterface

// File: rtl/dc_token_ring_sync.sv
// One-hot rotating token register; clear has priority over enable.
// W must not exceed dc_token_pkg::TOK_MAX.
module dc_token_ring_sync
    import dc_token_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] state
);

    always_ff @(posedge clk) begin
        if (rst || clear)
            state <= W'(TOK_RST);
        else if (enable)
            state <= W'(tok_rotl(tok_t'(state), W));
    end

endmodule

// File: rtl/dc_token_data_buffer.sv
// Single-clock FIFO storage addressed by one-hot write/read token rings.
// Define DC_TOKEN_BUF_LEVEL_EN to expose level and almost_full.
module dc_token_data_buffer
    import dc_token_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int BUFFER_DEPTH = 8,
    parameter int AF_THRESH    = 6
) (
    input logic                  clk,
    input logic                  rst,
    dc_token_data_buffer_if.slave bus
);

    localparam int CW = $clog2(BUFFER_DEPTH + 1);

    if (BUFFER_DEPTH < 2 || BUFFER_DEPTH > TOK_MAX ||
        AF_THRESH < 1 || AF_THRESH > BUFFER_DEPTH) begin : g_bad_param
        $error("dc_token_data_buffer: illegal BUFFER_DEPTH/AF_THRESH");
    end

    logic [BUFFER_DEPTH-1:0] wr_tok, rd_tok;
    logic [CW-1:0]           count, count_nxt;
    logic [DATA_WIDTH-1:0]   mem [BUFFER_DEPTH];
    logic                    full, empty, push, pop, wr_en;

    assign full  = (count == CW'(BUFFER_DEPTH));
    assign empty = (count == '0);
    // No write-through: a full buffer refuses even when a pop frees a slot this cycle.
    assign push  = bus.in_valid & ~full;
    assign pop   = bus.out_ready & ~empty;
    assign wr_en = push & ~bus.flush;

    assign bus.in_ready  = ~full;
    assign bus.out_valid = ~empty;

    dc_token_ring_sync #(.W(BUFFER_DEPTH)) u_wr_ring (
        .clk(clk), .rst(rst), .clear(bus.flush), .enable(push), .state(wr_tok)
    );

    dc_token_ring_sync #(.W(BUFFER_DEPTH)) u_rd_ring (
        .clk(clk), .rst(rst), .clear(bus.flush), .enable(pop), .state(rd_tok)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BUFFER_DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int i = 0; i < BUFFER_DEPTH; i++)
                if (wr_en && wr_tok[i]) mem[i] <= bus.in_data;
        end
    end

    always_comb begin
        count_nxt = count;
        if (bus.flush)
            count_nxt = '0;
        else if (push && !pop)
            count_nxt = count + CW'(1);
        else if (pop && !push)
            count_nxt = count - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) count <= '0;
        else     count <= count_nxt;
    end

    // Read mux built per bit column so each output bit is an AND-OR over slots.
    for (genvar b = 0; b < DATA_WIDTH; b++) begin : g_col
        logic [BUFFER_DEPTH-1:0] col;
        for (genvar i = 0; i < BUFFER_DEPTH; i++) begin : g_slot
            assign col[i] = mem[i][b];
        end
        assign bus.out_data[b] = tok_mux(tok_t'(rd_tok), tok_t'(col));
    end

`ifdef DC_TOKEN_BUF_LEVEL_EN
    logic af_q;

    // Registered from count_nxt so it lines up with level (which is count itself).
    always_ff @(posedge clk) begin
        if (rst) af_q <= 1'b0;
        else     af_q <= (int'(count_nxt) >= AF_THRESH);
    end

    assign bus.level       = count;
    assign bus.almost_full = af_q;
`endif

endmodule

// File: tb/tb_dc_token_data_buffer.sv
// Directed + random scoreboard bench for dc_token_data_buffer.
module tb_dc_token_data_buffer;

  localparam int DW = 32;
  localparam int DEPTH = 8;
  localparam int AF = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dc_token_data_buffer_if #(.DATA_WIDTH(DW), .BUFFER_DEPTH(DEPTH)) bus ();

  dc_token_data_buffer #(.DATA_WIDTH(DW), .BUFFER_DEPTH(DEPTH), .AF_THRESH(AF)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int vecs = 0;
  int errs = 0;
  logic [DW-1:0] mq[$];
  int wr_slot = 0;
  int rd_slot = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Checks state visible now, drives one cycle, then advances the model.
  task automatic cyc(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic fl);
    logic mpush, mpop;
    int n;
    bus.in_valid = iv;
    bus.in_data = d;
    bus.out_ready = ordy;
    bus.flush = fl;
    n = mq.size();
    mpush = iv && (n < DEPTH);
    mpop = ordy && (n > 0);
    chk("in_ready", 32'(bus.in_ready), 32'(n < DEPTH));
    chk("out_valid", 32'(bus.out_valid), 32'(n > 0));
    chk("count", 32'(dut.count), 32'(n));
    chk("wr_tok", 32'(dut.wr_tok), 32'(1) << wr_slot);
    chk("rd_tok", 32'(dut.rd_tok), 32'(1) << rd_slot);
`ifdef DC_TOKEN_BUF_LEVEL_EN
    chk("level", 32'(bus.level), 32'(n));
    chk("almost_full", 32'(bus.almost_full), 32'(n >= AF));
`endif
    if (mpop && !fl) chk("pop_data", bus.out_data, mq[0]);
    @(posedge clk);
    #1;
    if (fl) begin
      mq.delete();
      wr_slot = 0;
      rd_slot = 0;
    end else begin
      if (mpop) begin
        void'(mq.pop_front());
        rd_slot = (rd_slot + 1) % DEPTH;
      end
      if (mpush) begin
        mq.push_back(d);
        wr_slot = (wr_slot + 1) % DEPTH;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.flush = 1'b0;
    bus.in_data = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    wr_slot = 0;
    rd_slot = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) cyc(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    do_reset();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);

    // single beat, consumer stalled
    cyc(1'b1, 32'hA5, 1'b0, 1'b0);
    chk("t1_out_data", bus.out_data, 32'hA5);
    cyc(1'b0, '0, 1'b0, 1'b0);
    drain();

    // fill, held ninth push, drain in order with read-token wrap
    for (int i = 1; i <= 8; i++) cyc(1'b1, 32'(i), 1'b0, 1'b0);
    chk("t2_full_ready", 32'(bus.in_ready), 32'd0);
    cyc(1'b1, 32'd9, 1'b0, 1'b0);
    drain();

    // full with simultaneous push+pop: only the pop happens
    for (int i = 1; i <= 8; i++) cyc(1'b1, 32'(i), 1'b0, 1'b0);
    cyc(1'b1, 32'h100, 1'b1, 1'b0);
    chk("t3_count7", 32'(dut.count), 32'd7);
    cyc(1'b1, 32'h100, 1'b0, 1'b0);
    drain();

    // steady streaming at occupancy 3
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b1, 32'h300 + 32'(i), 1'b1, 1'b0);
    chk("t4_count3", 32'(dut.count), 32'd3);
    drain();

    // flush drops contents and the concurrent push
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h400 + 32'(i), 1'b0, 1'b0);
    cyc(1'b1, 32'hDEAD, 1'b0, 1'b1);
    chk("t5_out_valid", 32'(bus.out_valid), 32'd0);
    cyc(1'b1, 32'h55, 1'b0, 1'b0);
    chk("t5_slot0_data", bus.out_data, 32'h55);
    drain();

`ifdef DC_TOKEN_BUF_LEVEL_EN
    for (int i = 0; i < 6; i++) cyc(1'b1, 32'h600 + 32'(i), 1'b0, 1'b0);
    chk("t6_level6", 32'(bus.level), 32'd6);
    chk("t6_af1", 32'(bus.almost_full), 32'd1);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("t6_level5", 32'(bus.level), 32'd5);
    chk("t6_af0", 32'(bus.almost_full), 32'd0);
`else
    for (int i = 0; i < 6; i++) cyc(1'b1, 32'h600 + 32'(i), 1'b0, 1'b0);
`endif

    // reset mid-stream
    do_reset();
    chk("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mid_out_data", bus.out_data, 32'd0);
`ifdef DC_TOKEN_BUF_LEVEL_EN
    chk("rst_mid_level", 32'(bus.level), 32'd0);
`endif
    cyc(1'b0, '0, 1'b0, 1'b0);

    // random traffic with occasional flush
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 29) == 0));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
